// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU sharing arbiter.
package alu_arb_pkg;

    localparam int OPCODE_BIT_WIDTH_DFLT = 4;
    localparam int DBITS_DFLT            = 32;

    typedef logic [0:0] req_id_t;

    // Operand-B select encodings; bit 1 forces zero regardless of bit 0
    localparam logic [1:0] MUX_REG  = 2'b00;
    localparam logic [1:0] MUX_IMM  = 2'b01;
    localparam logic [1:0] MUX_ZERO = 2'b10;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin picker with next-pointer computation.
// Macro ALU_ARB_FIXED_PRI_EN: requester 0 gets strict priority and the pointer stays at 0.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic       v0_i,
    input  logic       v1_i,
    input  req_id_t    ptr_i,
    input  logic       accept_i,
    output logic [1:0] allow_o,
    output logic [1:0] grant_o,
    output req_id_t    ptr_nxt_o
);

`ifdef ALU_ARB_FIXED_PRI_EN
    assign allow_o   = {~v0_i, 1'b1};
    // Expression is constant zero; it only keeps the pointer inputs connected
    assign ptr_nxt_o = ptr_i & ~(ptr_i | accept_i);
`else
    // allow_o never looks at the requester's own valid, so ready stays independent of it
    assign allow_o[0] = ~v1_i | (ptr_i == 1'b0);
    assign allow_o[1] = ~v0_i | (ptr_i == 1'b1);
    assign ptr_nxt_o  = accept_i ? ~grant_o[1] : ptr_i;
`endif

    assign grant_o = {v1_i & allow_o[1], v0_i & allow_o[0]};

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one Execute ALU between two requesters: issue slot -> Execute -> result register.
// Macro ALU_ARB_FIXED_PRI_EN switches arbitration from round-robin to strict requester-0 priority.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int OPCODE_BIT_WIDTH = OPCODE_BIT_WIDTH_DFLT,
    parameter int DBITS            = DBITS_DFLT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [OPCODE_BIT_WIDTH-1:0] req0_op,
    input  logic [DBITS-1:0]            req0_a,
    input  logic [DBITS-1:0]            req0_b,
    input  logic [DBITS-1:0]            req0_imm,
    input  logic [1:0]                  req0_mux,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [OPCODE_BIT_WIDTH-1:0] req1_op,
    input  logic [DBITS-1:0]            req1_a,
    input  logic [DBITS-1:0]            req1_b,
    input  logic [DBITS-1:0]            req1_imm,
    input  logic [1:0]                  req1_mux,
    output logic                        rsp0_valid,
    input  logic                        rsp0_ready,
    output logic                        rsp1_valid,
    input  logic                        rsp1_ready,
    output logic [DBITS-1:0]            rsp_data,
    output logic                        rsp_cond,
    output logic [DBITS-1:0]            exe_reg1,
    output logic [DBITS-1:0]            exe_reg2,
    output logic [DBITS-1:0]            exe_imm,
    output logic [1:0]                  exe_mux,
    output logic [OPCODE_BIT_WIDTH-1:0] exe_op,
    input  logic [DBITS-1:0]            exe_out,
    input  logic                        exe_cond,
    output logic                        busy
);

    logic                        iss_valid_q, iss_valid_d;
    req_id_t                     iss_owner_q, iss_owner_d;
    logic [OPCODE_BIT_WIDTH-1:0] iss_op_q,    iss_op_d;
    logic [DBITS-1:0]            iss_a_q,     iss_a_d;
    logic [DBITS-1:0]            iss_b_q,     iss_b_d;
    logic [DBITS-1:0]            iss_imm_q,   iss_imm_d;
    logic [1:0]                  iss_mux_q,   iss_mux_d;

    logic                        res_valid_q, res_valid_d;
    req_id_t                     res_owner_q, res_owner_d;
    logic [DBITS-1:0]            res_data_q,  res_data_d;
    logic                        res_cond_q,  res_cond_d;

    req_id_t                     ptr_q, ptr_nxt_s;

    logic                        res_drain_s;
    logic                        iss_adv_s;
    logic                        iss_free_s;
    logic                        accept_s;
    logic [1:0]                  allow_s;
    logic [1:0]                  grant_s;

    assign res_drain_s = res_valid_q & ((res_owner_q == 1'b1) ? rsp1_ready : rsp0_ready);
    assign iss_adv_s   = iss_valid_q & (~res_valid_q | res_drain_s);
    assign iss_free_s  = ~iss_valid_q | iss_adv_s;

    alu_arb_rr u_rr (
        .v0_i      (req0_valid),
        .v1_i      (req1_valid),
        .ptr_i     (ptr_q),
        .accept_i  (accept_s),
        .allow_o   (allow_s),
        .grant_o   (grant_s),
        .ptr_nxt_o (ptr_nxt_s)
    );

    assign req0_ready = iss_free_s & allow_s[0];
    assign req1_ready = iss_free_s & allow_s[1];
    assign accept_s   = iss_free_s & (grant_s[0] | grant_s[1]);

    // Issue slot: load the winner, otherwise empty out (zeroing exe_*) once it advances
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_owner_d = iss_owner_q;
        iss_op_d    = iss_op_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_imm_d   = iss_imm_q;
        iss_mux_d   = iss_mux_q;
        if (accept_s) begin
            iss_valid_d = 1'b1;
            if (grant_s[1]) begin
                iss_owner_d = 1'b1;
                iss_op_d    = req1_op;
                iss_a_d     = req1_a;
                iss_b_d     = req1_b;
                iss_imm_d   = req1_imm;
                iss_mux_d   = req1_mux;
            end else begin
                iss_owner_d = 1'b0;
                iss_op_d    = req0_op;
                iss_a_d     = req0_a;
                iss_b_d     = req0_b;
                iss_imm_d   = req0_imm;
                iss_mux_d   = req0_mux;
            end
        end else if (iss_adv_s) begin
            iss_valid_d = 1'b0;
            iss_owner_d = 1'b0;
            iss_op_d    = '0;
            iss_a_d     = '0;
            iss_b_d     = '0;
            iss_imm_d   = '0;
            iss_mux_d   = 2'b00;
        end else begin
            iss_valid_d = iss_valid_q;
        end
    end

    // Result register: capture Execute on advance, release on drain, otherwise hold
    always_comb begin
        res_valid_d = res_valid_q;
        res_owner_d = res_owner_q;
        res_data_d  = res_data_q;
        res_cond_d  = res_cond_q;
        if (iss_adv_s) begin
            res_valid_d = 1'b1;
            res_owner_d = iss_owner_q;
            res_data_d  = exe_out;
            res_cond_d  = exe_cond;
        end else if (res_drain_s) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers; reset discards any in-flight op without a response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_owner_q <= 1'b0;
            iss_op_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_imm_q   <= '0;
            iss_mux_q   <= 2'b00;
            res_valid_q <= 1'b0;
            res_owner_q <= 1'b0;
            res_data_q  <= '0;
            res_cond_q  <= 1'b0;
            ptr_q       <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_owner_q <= iss_owner_d;
            iss_op_q    <= iss_op_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_imm_q   <= iss_imm_d;
            iss_mux_q   <= iss_mux_d;
            res_valid_q <= res_valid_d;
            res_owner_q <= res_owner_d;
            res_data_q  <= res_data_d;
            res_cond_q  <= res_cond_d;
            ptr_q       <= ptr_nxt_s;
        end
    end

    assign exe_reg1   = iss_a_q;
    assign exe_reg2   = iss_b_q;
    assign exe_imm    = iss_imm_q;
    assign exe_mux    = iss_mux_q;
    assign exe_op     = iss_op_q;
    assign rsp0_valid = res_valid_q & (res_owner_q == 1'b0);
    assign rsp1_valid = res_valid_q & (res_owner_q == 1'b1);
    assign rsp_data   = res_data_q;
    assign rsp_cond   = res_cond_q;
    assign busy       = iss_valid_q | res_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a stand-in Execute ALU (reg1 + muxed B).
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        bit          cond;
        logic [3:0]  op;
        logic [31:0] a;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req0_imm, req1_a, req1_b, req1_imm;
    logic [1:0]  req0_mux, req1_mux;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_cond;
    logic [31:0] exe_reg1, exe_reg2, exe_imm, exe_out;
    logic [1:0]  exe_mux;
    logic [3:0]  exe_op;
    logic        exe_cond;
    logic        busy;
    logic [31:0] alu_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.OPCODE_BIT_WIDTH(4), .DBITS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm), .req0_mux(req0_mux),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm), .req1_mux(req1_mux),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_cond(rsp_cond),
        .exe_reg1(exe_reg1), .exe_reg2(exe_reg2), .exe_imm(exe_imm),
        .exe_mux(exe_mux), .exe_op(exe_op),
        .exe_out(exe_out), .exe_cond(exe_cond), .busy(busy)
    );

    // Stand-in for the parent's Execute instance
    always_comb begin
        if (exe_mux[1])      alu_b = 32'd0;
        else if (exe_mux[0]) alu_b = exe_imm;
        else                 alu_b = exe_reg2;
        exe_out  = exe_reg1 + alu_b;
        exe_cond = (exe_out == 32'd0);
    end

    function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [1:0] mux);
        if (mux[1])      return a;
        else if (mux[0]) return a + imm;
        else             return a + b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd11; req0_b = 32'd22; req1_a = 32'd33; req1_b = 32'd44;
        @(posedge clk);
        #2;
        checks++; if ({rsp0_valid, rsp1_valid, busy, rsp_cond} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {rsp0_valid, rsp1_valid, busy, rsp_cond}); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", rsp_data); end
        checks++; if ({exe_reg1, exe_reg2, exe_imm, exe_mux, exe_op} !== 102'd0) begin errors++; $display("FAIL reset_exe got %h/%h/%h/%b/%h exp 0", exe_reg1, exe_reg2, exe_imm, exe_mux, exe_op); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        step();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_imm = 32'hdead; req0_mux = MUX_REG; req0_op = 4'h2;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        #1;
        checks++; if ({rsp0_valid, busy} !== 2'b01) begin errors++; $display("FAIL basic_t1 got %b exp 01", {rsp0_valid, busy}); end
        checks++; if ({exe_reg1, exe_reg2, exe_op} !== {32'd5, 32'd7, 4'h2}) begin errors++; $display("FAIL basic_exe got %0d %0d %h exp 5 7 2", exe_reg1, exe_reg2, exe_op); end
        step();
        #1;
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errors++; $display("FAIL basic_rspv got %b exp 10", {rsp0_valid, rsp1_valid}); end
        checks++; if ({rsp_data, rsp_cond} !== {32'd12, 1'b0}) begin errors++; $display("FAIL basic_data got %0d/%b exp 12/0", rsp_data, rsp_cond); end
        step();
        #1;
        checks++; if ({rsp0_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_done got %b exp 00", {rsp0_valid, busy}); end
    endtask

    task automatic test_contention();
        ent_t exp_q[$];
        ent_t e;
        int   w;
        rst_pulse();
        req0_mux = MUX_REG; req1_mux = MUX_REG;
        for (int i = 0; i < 12; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
            req0_op = 4'($urandom); req1_op = 4'($urandom);
            #1;
`ifdef ALU_ARB_FIXED_PRI_EN
            w = 0;
`else
            w = i % 2;
`endif
            checks++; if ({req1_ready, req0_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_grant i=%0d got %b exp winner %0d", i, {req1_ready, req0_ready}, w); end
            e.owner = (w == 1);
            e.data  = (w == 1) ? req1_a + req1_b : req0_a + req0_b;
            e.cond  = (e.data == 32'd0);
            exp_q.push_back(e);
            if (i >= 2) begin
                e = exp_q.pop_front();
                checks++; if ({rsp1_valid, rsp0_valid} !== (e.owner ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_owner i=%0d got %b exp owner %0d", i, {rsp1_valid, rsp0_valid}, e.owner); end
                checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL cont_data i=%0d got %h exp %h", i, rsp_data, e.data); end
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            e = exp_q.pop_front();
            checks++; if ({rsp1_valid, rsp0_valid} !== (e.owner ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_tail_owner got %b exp owner %0d", {rsp1_valid, rsp0_valid}, e.owner); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL cont_tail_data got %h exp %h", rsp_data, e.data); end
            step();
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        rst_pulse();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_mux = MUX_REG;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_acc_a got %b exp 1", req0_ready); end
        step();
        req0_a = 32'd1; req0_b = 32'd2;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_acc_b got %b exp 1", req0_ready); end
        step();
        req0_a = 32'd100; req0_b = 32'd0;
        req1_valid = 1'b1; req1_a = 32'd50; req1_b = 32'd50; req1_mux = MUX_REG;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready k=%0d got %b exp 00", k, {req0_ready, req1_ready}); end
            checks++; if ({rsp0_valid, rsp_data} !== {1'b1, 32'd30}) begin errors++; $display("FAIL bp_hold k=%0d got %b/%0d exp 1/30", k, rsp0_valid, rsp_data); end
            checks++; if (exe_reg1 !== 32'd1) begin errors++; $display("FAIL bp_iss k=%0d got %0d exp 1", k, exe_reg1); end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
        #1;
        checks++; if ({rsp0_valid, rsp_data} !== {1'b1, 32'd30}) begin errors++; $display("FAIL bp_rel_a got %b/%0d exp 1/30", rsp0_valid, rsp_data); end
        step();
        #1;
        checks++; if ({rsp0_valid, rsp_data} !== {1'b1, 32'd3}) begin errors++; $display("FAIL bp_rel_b got %b/%0d exp 1/3", rsp0_valid, rsp_data); end
        step();
        #1;
        checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errors++; $display("FAIL bp_empty got %b exp 000", {rsp0_valid, rsp1_valid, busy}); end
    endtask

    task automatic test_mux();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [31:0] ti [4];
        logic [1:0]  tm [4];
        logic [31:0] ed [4];
        logic        ec [4];
        ta = '{32'd4,  32'd0,  32'd9, 32'd8};
        tb = '{32'd99, 32'd55, 32'd5, 32'd2};
        ti = '{32'd3,  32'd9,  32'd6, 32'd1};
        tm = '{MUX_IMM, MUX_ZERO, 2'b11, MUX_REG};
        ed = '{32'd7,  32'd0,  32'd9, 32'd10};
        ec = '{1'b0,   1'b1,   1'b0,  1'b0};
        rst_pulse();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i]; req0_imm = ti[i]; req0_mux = tm[i];
            end else begin
                req0_valid = 1'b0;
            end
            #1;
            if (i >= 2) begin
                checks++; if ({rsp0_valid, rsp_data, rsp_cond} !== {1'b1, ed[i-2], ec[i-2]}) begin errors++; $display("FAIL mux_%0d got %b/%0d/%b exp 1/%0d/%b", i-2, rsp0_valid, rsp_data, rsp_cond, ed[i-2], ec[i-2]); end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        rst_pulse();
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_mux = MUX_REG;
        step();
        req0_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_inflight got busy=%b exp 1", busy); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL ar_clear got %b exp 000", {busy, rsp0_valid, rsp1_valid}); end
        checks++; if ({exe_reg1, exe_reg2} !== 64'd0) begin errors++; $display("FAIL ar_exe got %0d/%0d exp 0/0", exe_reg1, exe_reg2); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errors++; $display("FAIL ar_norsp k=%0d got %b exp 000", k, {rsp0_valid, rsp1_valid, busy}); end
            step();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL ar_first got %b exp 01", {req1_ready, req0_ready}); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step();
    endtask

`ifdef ALU_ARB_FIXED_PRI_EN
    task automatic test_fixed_pri();
        rst_pulse();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL fp_starve k=%0d got %b exp 01", k, {req1_ready, req0_ready}); end
            step();
        end
        req0_valid = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL fp_serve got %b exp 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        step(); step(); step();
    endtask
`endif

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        bit   res_full, iss_full, drain, adv, free, acc0, acc1, m_ptr;
        logic exp_r0, exp_r1;
        rst_pulse();
        res_full = 1'b0; iss_full = 1'b0; m_ptr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            req1_a = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            req0_b = $urandom; req1_b = $urandom; req0_imm = $urandom; req1_imm = $urandom;
            req0_mux = 2'($urandom_range(0, 3)); req1_mux = 2'($urandom_range(0, 3));
            req0_op = 4'($urandom); req1_op = 4'($urandom);
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++; if ({rsp1_valid, rsp0_valid, busy} !== {res_full && q[0].owner, res_full && !q[0].owner, res_full || iss_full}) begin errors++; $display("FAIL rnd_valid i=%0d got %b exp %b", i, {rsp1_valid, rsp0_valid, busy}, {res_full && q[0].owner, res_full && !q[0].owner, res_full || iss_full}); end
            if (res_full) begin
                checks++; if ({rsp_data, rsp_cond} !== {q[0].data, q[0].cond}) begin errors++; $display("FAIL rnd_data i=%0d got %h/%b exp %h/%b", i, rsp_data, rsp_cond, q[0].data, q[0].cond); end
            end
            if (iss_full) begin
                e = q[res_full ? 1 : 0];
                checks++; if ({exe_op, exe_reg1} !== {e.op, e.a}) begin errors++; $display("FAIL rnd_exe i=%0d got %h/%h exp %h/%h", i, exe_op, exe_reg1, e.op, e.a); end
            end else begin
                checks++; if ({exe_op, exe_reg1, exe_mux} !== 38'd0) begin errors++; $display("FAIL rnd_exe0 i=%0d got %h/%h/%b exp 0", i, exe_op, exe_reg1, exe_mux); end
            end
            drain = res_full && (q[0].owner ? rsp1_ready : rsp0_ready);
            adv   = iss_full && (!res_full || drain);
            free  = !iss_full || adv;
`ifdef ALU_ARB_FIXED_PRI_EN
            exp_r0 = free;
            exp_r1 = free && !req0_valid;
`else
            exp_r0 = free && (!req1_valid || m_ptr == 1'b0);
            exp_r1 = free && (!req0_valid || m_ptr == 1'b1);
`endif
            checks++; if ({req1_ready, req0_ready} !== {exp_r1, exp_r0}) begin errors++; $display("FAIL rnd_ready i=%0d got %b exp %b", i, {req1_ready, req0_ready}, {exp_r1, exp_r0}); end
            acc0 = req0_valid && exp_r0;
            acc1 = req1_valid && exp_r1;
            if (drain) void'(q.pop_front());
            res_full = adv || (res_full && !drain);
            iss_full = acc0 || acc1 || (iss_full && !adv);
            if (acc0 || acc1) begin
                e.owner = acc1;
                e.a     = acc1 ? req1_a : req0_a;
                e.op    = acc1 ? req1_op : req0_op;
                e.data  = acc1 ? ref_alu(req1_a, req1_b, req1_imm, req1_mux) : ref_alu(req0_a, req0_b, req0_imm, req0_mux);
                e.cond  = (e.data == 32'd0);
                q.push_back(e);
`ifndef ALU_ARB_FIXED_PRI_EN
                m_ptr = acc1 ? 1'b0 : 1'b1;
`endif
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step(); step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_drain got busy=%b exp 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 4'h0; req1_op = 4'h0;
        req0_a = 32'd0; req0_b = 32'd0; req0_imm = 32'd0; req0_mux = 2'b00;
        req1_a = 32'd0; req1_b = 32'd0; req1_imm = 32'd0; req1_mux = 2'b00;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_reset();
        test_basic();
        test_contention();
        test_backpressure();
        test_mux();
        test_async_reset();
`ifdef ALU_ARB_FIXED_PRI_EN
        test_fixed_pri();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
